// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the iterative fixed-point divider: FSM state
// encoding plus width helpers derived from the operand/result formats.
package fixedpoint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of quotient bits produced, one per CALC cycle.
    function automatic int calc_nw(input int wi1, input int wf1, input int wf2, input int wfo);
        return wi1 + wf1 + wf2 + wfo;
    endfunction

    // Partial remainder width: scaled divisor plus one guard bit for the shift.
    function automatic int calc_rw(input int wi2, input int wf2, input int wf1);
        return wi2 + wf2 + wf1 + 1;
    endfunction

    // Values for the default Q3.4 / Q4.3 -> Q5.6 configuration.
    localparam int              DEF_NW      = 16;
    localparam int              DEF_RW      = 12;
    localparam int              DEF_WO      = 11;
    localparam logic [10:0]     DEF_OUT_MAX = 11'h3FF;
    localparam logic [10:0]     DEF_OUT_MIN = 11'h400;

endpackage

// File: rtl/fixedpoint_saturate.sv
// Applies the result sign to an unsigned quotient magnitude and clamps it
// into the signed output range, flagging overflow when clamping occurs.
module fixedpoint_saturate #(
    parameter int MW = 16,
    parameter int WO = 11
) (
    input  logic [MW-1:0] mag,
    input  logic          neg,
    output logic [WO-1:0] q,
    output logic          ovf
);
    // Comparison width wide enough for both the magnitude and 2^(WO-1).
    localparam int CW = (MW > WO) ? MW + 1 : WO + 1;

    localparam logic [CW-1:0] POS_LIM = (CW'(1) << (WO - 1)) - CW'(1);
    localparam logic [CW-1:0] NEG_LIM = CW'(1) << (WO - 1);
    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

    logic [CW-1:0] mag_x;
    assign mag_x = CW'(mag);

    // Negative side allows one extra count: exactly -2^(WO-1) is representable.
    always_comb begin
        q   = '0;
        ovf = 1'b0;
        if (!neg) begin
            if (mag_x > POS_LIM) begin
                q   = OUT_MAX;
                ovf = 1'b1;
            end else begin
                q = mag_x[WO-1:0];
            end
        end else begin
            if (mag_x > NEG_LIM) begin
                q   = OUT_MIN;
                ovf = 1'b1;
            end else begin
                q = -mag_x[WO-1:0];
            end
        end
    end

endmodule

// File: rtl/fixedpoint_divider_iterative.sv
// Iterative signed fixed-point divider. Operands are converted to unsigned
// magnitudes, divided by restoring long division (one quotient bit per
// cycle), then re-signed and saturated into Q(WIO).(WFO).
module fixedpoint_divider_iterative
    import fixedpoint_pkg::*;
#(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = 5,
    parameter int WFO = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   dividend,
    input  logic [WI2+WF2-1:0]   divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   quotient,
    output logic                 overflow,
    output logic                 div_zero
);
    localparam int WA   = WI1 + WF1;
    localparam int WB   = WI2 + WF2;
    localparam int WO   = WIO + WFO;
    localparam int NW   = calc_nw(WI1, WF1, WF2, WFO);
    localparam int RW   = calc_rw(WI2, WF2, WF1);
    localparam int DW   = RW - 1;
    localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [NW-1:0]   num;     // numerator bits shift out the top, quotient bits shift in
    logic [DW-1:0]   den;     // divisor magnitude aligned to the dividend's fraction
    logic [RW-1:0]   rem;
    logic            neg;

    logic [WA-1:0]   a_mag;
    logic [WB-1:0]   b_mag;
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   rem_nxt;
    logic            q_bit;
    logic [WO-1:0]   sat_q;
    logic            sat_ovf;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Unsigned magnitudes; the most negative value maps to 2^(W-1), which fits.
    always_comb begin
        a_mag = dividend[WA-1] ? -dividend : dividend;
        b_mag = divisor[WB-1]  ? -divisor  : divisor;
    end

    // One restoring step: shift in next numerator bit, subtract if it fits.
    always_comb begin
        rem_sh  = RW'({rem, num[NW-1]});
        q_bit   = (rem_sh >= RW'(den));
        rem_nxt = q_bit ? (rem_sh - RW'(den)) : rem_sh;
    end

    fixedpoint_saturate #(
        .MW (NW),
        .WO (WO)
    ) u_sat (
        .mag (num),
        .neg (neg),
        .q   (sat_q),
        .ovf (sat_ovf)
    );

    // Control FSM and iteration datapath; reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            num      <= '0;
            den      <= '0;
            rem      <= '0;
            neg      <= 1'b0;
            quotient <= '0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient <= dividend[WA-1] ? OUT_MIN : OUT_MAX;
                            overflow <= 1'b0;
                            div_zero <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            num   <= NW'(a_mag) << (WF2 + WFO);
                            den   <= DW'(b_mag) << WF1;
                            rem   <= '0;
                            neg   <= dividend[WA-1] ^ divisor[WB-1];
                            cnt   <= CNTW'(NW - 1);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem <= rem_nxt;
                    num <= {num[NW-2:0], q_bit};
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - CNTW'(1);
                end
                ST_FIX: begin
                    quotient <= sat_q;
                    overflow <= sat_ovf;
                    div_zero <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        overflow <= 1'b0;
                        div_zero <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixedpoint_divider_iterative.sv
// Directed bench for the iterative fixed-point divider at default widths.
module tb_fixedpoint_divider_iterative;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  dividend;
    logic [6:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] quotient;
    logic        overflow;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    fixedpoint_divider_iterative dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Present operands, wait for acceptance; returns at the accept edge + #1.
    task automatic issue(input logic [6:0] a, input logic [6:0] b, output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) ok = 1'b0;
        in_valid = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count clock periods from the accept edge until out_valid; -1 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Full transaction: issue, wait, capture, handshake.
    task automatic do_op(input logic [6:0] a, input logic [6:0] b,
                         output logic [10:0] q, output logic ov, output logic dz, output int lat);
        bit ok;
        issue(a, b, ok);
        wait_result(lat);
        if (!ok) lat = -1;
        q = quotient; ov = overflow; dz = div_zero;
        release_result();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (quotient !== 11'h000) begin bad++; $display("FAIL reset_quotient got=%h want=000", quotient); end
        total++; if ({overflow, div_zero} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow, div_zero}); end
        reset = 1'b0;
    endtask

    // Signed and unsigned cases, truncation toward zero, saturation boundaries.
    task automatic test_divide();
        logic [6:0]  va [6] = '{7'h18, 7'h68, 7'h10, 7'h70, 7'h3F, 7'h40};
        logic [6:0]  vb [6] = '{7'h04, 7'h04, 7'h18, 7'h18, 7'h01, 7'h02};
        logic [10:0] vq [6] = '{11'h0C0, 11'h740, 11'h015, 11'h7EB, 11'h3FF, 11'h400};
        logic        vo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [10:0] q; logic ov, dz; int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], q, ov, dz, lat);
            total++; if (q !== vq[i])  begin bad++; $display("FAIL div%0d_quotient got=%h want=%h", i, q, vq[i]); end
            total++; if (ov !== vo[i]) begin bad++; $display("FAIL div%0d_overflow got=%b want=%b", i, ov, vo[i]); end
            total++; if (dz !== 1'b0)  begin bad++; $display("FAIL div%0d_div_zero got=%b want=0", i, dz); end
            total++; if (lat != 18)    begin bad++; $display("FAIL div%0d_latency got=%0d want=18", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [6:0]  va [2] = '{7'h70, 7'h00};
        logic [10:0] vq [2] = '{11'h400, 11'h3FF};
        logic [10:0] q; logic ov, dz; int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], 7'h00, q, ov, dz, lat);
            total++; if (q !== vq[i]) begin bad++; $display("FAIL dz%0d_quotient got=%h want=%h", i, q, vq[i]); end
            total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz%0d_div_zero got=%b want=1", i, dz); end
            total++; if (ov !== 1'b0) begin bad++; $display("FAIL dz%0d_overflow got=%b want=0", i, ov); end
            total++; if (lat != 1)    begin bad++; $display("FAIL dz%0d_latency got=%0d want=1", i, lat); end
        end
    endtask

    // Stall in DONE, poke in_valid, then release and go straight into another op.
    task automatic test_back_to_back();
        logic [10:0] q; logic ov, dz; int lat; bit ok;
        issue(7'h18, 7'h04, ok);
        wait_result(lat);
        total++; if (!ok || lat != 18) begin bad++; $display("FAIL bp_latency got=%0d want=18", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; dividend = 7'h10; divisor = 7'h18;
            @(negedge clk);
            total++; if (quotient !== 11'h0C0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin bad++; $display("FAIL bp_hold%0d got q=%h ov=%b ir=%b want q=0c0 ov=1 ir=0", c, quotient, out_valid, in_ready); end
        end
        in_valid = 1'b0;
        release_result();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        do_op(7'h70, 7'h18, q, ov, dz, lat);
        total++; if (q !== 11'h7EB || lat != 18) begin bad++; $display("FAIL b2b_quotient got=%h lat=%0d want=7eb lat=18", q, lat); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] q; logic ov, dz; int lat; bit ok; bit seen = 1'b0;
        issue(7'h3F, 7'h01, ok);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 11'h000)
            begin bad++; $display("FAIL rst_mid got ir=%b ov=%b q=%h want ir=1 ov=0 q=000", in_ready, out_valid, quotient); end
        reset = 1'b0;
        repeat (25) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        total++; if (seen) begin bad++; $display("FAIL rst_mid_no_result got out_valid=1 want 0"); end
        do_op(7'h68, 7'h04, q, ov, dz, lat);
        total++; if (q !== 11'h740 || ov !== 1'b0 || lat != 18)
            begin bad++; $display("FAIL rst_mid_after got q=%h ovf=%b lat=%0d want 740 0 18", q, ov, lat); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        test_reset();
        test_divide();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
